// File: rtl/row_cfg_pkg.sv
// rtl/row_cfg_pkg.sv - shared types and constants for the row configuration loader
// Purpose: loader state encoding, CRC-16-CCITT constants and default widths.
// Ports: none (package).
package row_cfg_pkg;

   localparam int WORD_W_DEFAULT = 32;
   localparam int CNT_W_DEFAULT  = 16;

   localparam logic [15:0] CRC_POLY = 16'h1021;
   localparam logic [15:0] CRC_INIT = 16'hFFFF;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_SHIFT,
      ST_CHECK,
      ST_DONE
   } state_t;

endpackage

// File: rtl/crc16_serial.sv
// rtl/crc16_serial.sv - bit-serial CRC-16-CCITT accumulator
// Purpose: folds one bit per enabled cycle into a CRC-16 (poly 0x1021, no reflection, no final XOR).
// Ports:
//   clk       in  clock, rising edge
//   rst       in  synchronous active-high reset, loads CRC_INIT
//   clear     in  reload CRC_INIT (start of a new bitstream)
//   enable    in  fold shift_bit into the CRC this cycle
//   shift_bit in  bit being shifted out
//   crc       out current CRC state
module crc16_serial
   import row_cfg_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        clear,
   input  logic        enable,
   input  logic        shift_bit,
   output logic [15:0] crc
);

   logic fb;

   assign fb = crc[15] ^ shift_bit;

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         crc <= CRC_INIT;
      end else if (enable) begin
         crc <= {crc[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
      end
   end

endmodule

// File: rtl/row_config_loader.sv
// rtl/row_config_loader.sv - streams host words LSB-first into a row config chain with CRC check
// Purpose: accepts a bit count and expected CRC, pulls WORD_W-bit words from the host,
//          shifts exactly bit_count bits into the chain and verifies the CRC of that bitstream.
// Ports:
//   prog_clk   in  clock, rising edge
//   prog_rst   in  synchronous active-high reset
//   start      in  begin a load (honoured only when idle)
//   bit_count  in  number of chain bits, latched on accepted start
//   exp_crc    in  expected CRC, latched on accepted start
//   abort      in  cancel the current load
//   s_data     in  host configuration word
//   s_valid    in  s_data valid
//   s_ready    out word accepted this cycle when s_valid is high
//   chain_en   out chain shift enable
//   chain_data out chain serial data
//   busy       out loader not idle
//   done       out one-cycle completion pulse
//   crc_err    out sticky CRC mismatch flag
//   crc_out    out running/final CRC
module row_config_loader
   import row_cfg_pkg::*;
#(
   parameter int WORD_W = WORD_W_DEFAULT,
   parameter int CNT_W  = CNT_W_DEFAULT
)
(
   input  logic              prog_clk,
   input  logic              prog_rst,
   input  logic              start,
   input  logic [CNT_W-1:0]  bit_count,
   input  logic [15:0]       exp_crc,
   input  logic              abort,
   input  logic [WORD_W-1:0] s_data,
   input  logic              s_valid,
   output logic              s_ready,
   output logic              chain_en,
   output logic              chain_data,
   output logic              busy,
   output logic              done,
   output logic              crc_err,
   output logic [15:0]       crc_out
);

   localparam int WC_W = $clog2(WORD_W + 1);
   localparam logic [WC_W-1:0] WORD_BITS = WC_W'(WORD_W);

   state_t            state;
   logic [WORD_W-1:0] shift_reg;
   logic [CNT_W-1:0]  remaining;
   logic [WC_W-1:0]   word_cnt;
   logic [15:0]       exp_crc_q;
   logic              accept_start;
   logic              shifting;

   assign accept_start = (state == ST_IDLE) && start;

   // Abort must silence the chain and the host handshake in the very cycle it is
   // raised, so these strobes are decoded from state and abort rather than registered.
   assign shifting   = (state == ST_SHIFT) && !abort;
   assign s_ready    = (state == ST_LOAD) && !abort;
   assign chain_en   = shifting;
   assign chain_data = shifting & shift_reg[0];
   assign busy       = (state != ST_IDLE);

   crc16_serial u_crc (
      .clk       (prog_clk),
      .rst       (prog_rst),
      .clear     (accept_start),
      .enable    (shifting),
      .shift_bit (shift_reg[0]),
      .crc       (crc_out)
   );

   always_ff @(posedge prog_clk) begin
      if (prog_rst) begin
         state     <= ST_IDLE;
         shift_reg <= '0;
         remaining <= '0;
         word_cnt  <= '0;
         exp_crc_q <= '0;
         crc_err   <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         if ((state != ST_IDLE) && abort) begin
            state <= ST_IDLE;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (start) begin
                     remaining <= bit_count;
                     exp_crc_q <= exp_crc;
                     crc_err   <= 1'b0;
                     state     <= (bit_count == '0) ? ST_CHECK : ST_LOAD;
                  end
               end
               ST_LOAD: begin
                  if (s_valid) begin
                     shift_reg <= s_data;
                     word_cnt  <= WORD_BITS;
                     state     <= ST_SHIFT;
                  end
               end
               ST_SHIFT: begin
                  shift_reg <= shift_reg >> 1;
                  remaining <= remaining - CNT_W'(1);
                  word_cnt  <= word_cnt - WC_W'(1);
                  // Running out of total bits wins over running out of the word, which
                  // is how leftover high bits of the final word get dropped.
                  if (remaining == CNT_W'(1)) begin
                     state <= ST_CHECK;
                  end else if (word_cnt == WC_W'(1)) begin
                     state <= ST_LOAD;
                  end
               end
               ST_CHECK: begin
                  crc_err <= (crc_out != exp_crc_q);
                  state   <= ST_DONE;
               end
               ST_DONE: begin
                  done  <= 1'b1;
                  state <= ST_IDLE;
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_row_config_loader.sv
// tb/tb_row_config_loader.sv - scoreboard bench for row_config_loader
module tb_row_config_loader;

   localparam int WORD_W = 32;
   localparam int CNT_W  = 16;

   typedef struct packed {
      logic [15:0] crc;
      logic        err;
   } done_t;

   logic              prog_clk;
   logic              prog_rst;
   logic              start;
   logic [CNT_W-1:0]  bit_count;
   logic [15:0]       exp_crc;
   logic              abort;
   logic [WORD_W-1:0] s_data;
   logic              s_valid;
   logic              s_ready;
   logic              chain_en;
   logic              chain_data;
   logic              busy;
   logic              done;
   logic              crc_err;
   logic [15:0]       crc_out;

   bit          exp_bits[$];
   done_t       exp_done[$];
   logic [31:0] word_q[$];
   int          gap_q[$];

   int n_cmp  = 0;
   int n_fail = 0;
   int chain_cnt = 0;

   row_config_loader #(.WORD_W(WORD_W), .CNT_W(CNT_W)) dut (
      .prog_clk   (prog_clk),
      .prog_rst   (prog_rst),
      .start      (start),
      .bit_count  (bit_count),
      .exp_crc    (exp_crc),
      .abort      (abort),
      .s_data     (s_data),
      .s_valid    (s_valid),
      .s_ready    (s_ready),
      .chain_en   (chain_en),
      .chain_data (chain_data),
      .busy       (busy),
      .done       (done),
      .crc_err    (crc_err),
      .crc_out    (crc_out)
   );

   initial prog_clk = 1'b0;
   always #5 prog_clk = ~prog_clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // CRC-16-CCITT of one more bit, straight from the polynomial definition.
   function automatic logic [15:0] crc_step(input logic [15:0] c, input bit b);
      logic fb;
      fb = c[15] ^ b;
      return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
   endfunction

   // Monitor: compares every chain bit and every completion against the scoreboard.
   bit    mon_bit;
   done_t mon_done;
   always @(negedge prog_clk) begin
      if (!prog_rst) begin
         if (chain_en) begin
            chain_cnt++;
            if (exp_bits.size() == 0) begin
               chk("spurious_chain_en", chain_en, 0);
            end else begin
               mon_bit = exp_bits.pop_front();
               chk("chain_data", chain_data, mon_bit);
            end
         end
         if (s_ready && !s_valid) chk("stall_chain_en", chain_en, 0);
         if (done) begin
            if (exp_done.size() == 0) begin
               chk("spurious_done", done, 0);
            end else begin
               mon_done = exp_done.pop_front();
               chk("done_crc_out", crc_out, mon_done.crc);
               chk("done_crc_err", crc_err, mon_done.err);
            end
         end
      end
   end

   // Host word feeder; a word's gap counts cycles the loader was ready but no word was offered.
   initial begin
      logic acc;
      logic rdy;
      s_valid = 1'b0;
      s_data  = '0;
      forever begin
         @(negedge prog_clk);
         acc = s_valid && s_ready;
         rdy = s_ready;
         @(posedge prog_clk);
         #1;
         if (acc && word_q.size() > 0) begin
            void'(word_q.pop_front());
            void'(gap_q.pop_front());
         end
         if (word_q.size() == 0) begin
            s_valid = 1'b0;
         end else begin
            if (rdy && !acc && gap_q[0] > 0) gap_q[0] = gap_q[0] - 1;
            s_valid = (gap_q[0] == 0);
            if (s_valid) s_data = word_q[0];
         end
      end
   end

   task automatic start_load(input int bc, input bit flip, input int gap2, input bit fix0,
                             input logic [31:0] w0, output logic [15:0] model_crc);
      logic [31:0] w;
      logic [15:0] c;
      done_t       d;
      int          nw;
      c  = 16'hFFFF;
      nw = (bc + 31) / 32;
      for (int i = 0; i < nw; i++) begin
         w = (i == 0 && fix0) ? w0 : $urandom;
         word_q.push_back(w);
         gap_q.push_back(i == 0 ? 0 : ((i == 1 && gap2 >= 0) ? gap2 : int'($urandom_range(0, 2))));
         for (int j = 0; j < 32; j++) begin
            if (i * 32 + j < bc) begin
               exp_bits.push_back(w[j]);
               c = crc_step(c, w[j]);
            end
         end
      end
      model_crc = c;
      d.crc = c;
      d.err = flip;
      exp_done.push_back(d);
      chain_cnt = 0;
      @(posedge prog_clk);
      #1;
      start     = 1'b1;
      bit_count = bc[15:0];
      exp_crc   = flip ? (c ^ 16'h0001) : c;
   endtask

   task automatic wait_done(input bit stray, output int done_at);
      int n;
      n = 0;
      done_at = -1;
      while (exp_done.size() > 0 && n < 4000) begin
         @(posedge prog_clk);
         #1;
         n++;
         // Scramble the latched-on-start inputs; optionally fire starts while busy.
         exp_crc = $urandom;
         if (stray && busy && $urandom_range(0, 3) == 0) begin
            start     = 1'b1;
            bit_count = CNT_W'($urandom_range(1, 5));
         end else begin
            start     = 1'b0;
            bit_count = CNT_W'($urandom);
         end
         if (done && done_at < 0) done_at = n;
      end
      start = 1'b0;
      if (exp_done.size() > 0) chk("done_timeout", exp_done.size(), 0);
   endtask

   task automatic flush_all();
      exp_bits.delete();
      exp_done.delete();
      word_q.delete();
      gap_q.delete();
   endtask

   task automatic chk_reset_values(input string tag);
      chk({tag, "_s_ready"}, s_ready, 0);
      chk({tag, "_chain_en"}, chain_en, 0);
      chk({tag, "_chain_data"}, chain_data, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_crc_err"}, crc_err, 0);
      chk({tag, "_crc_out"}, crc_out, 16'hFFFF);
   endtask

   task automatic normal_load(input int bc, input bit flip, input int gap2, input bit stray);
      logic [15:0] c;
      int          da;
      start_load(bc, flip, gap2, 1'b0, 32'h0, c);
      wait_done(stray, da);
      chk("load_chain_count", chain_cnt, bc);
      chk("load_bits_left", exp_bits.size(), 0);
      chk("load_crc_held", crc_out, c);
   endtask

   initial begin
      logic [15:0] c;
      int          da;
      int          n;

      prog_rst  = 1'b1;
      start     = 1'b0;
      abort     = 1'b0;
      bit_count = '0;
      exp_crc   = '0;
      repeat (3) @(posedge prog_clk);
      #1;
      prog_rst = 1'b0;
      chk_reset_values("reset");

      // Zero-length load: straight to CHECK, done three cycles after start.
      start_load(0, 1'b0, -1, 1'b0, 32'h0, c);
      wait_done(1'b0, da);
      chk("bc0_done_latency", da, 3);
      chk("bc0_chain_count", chain_cnt, 0);
      chk("bc0_crc_out", crc_out, 16'hFFFF);
      chk("bc0_crc_err", crc_err, 0);

      // Single byte 0xA5, LSB first.
      start_load(8, 1'b0, -1, 1'b1, 32'h0000_00A5, c);
      wait_done(1'b0, da);
      chk("a5_chain_count", chain_cnt, 8);
      chk("a5_crc_out", crc_out, c);
      chk("a5_crc_err", crc_err, 0);

      // 40 bits over two words with a 5-cycle host stall before the second.
      normal_load(40, 1'b0, 5, 1'b0);

      // Wrong expected CRC: sticky error until the next start.
      start_load(int'($urandom_range(1, 70)), 1'b1, -1, 1'b0, 32'h0, c);
      wait_done(1'b0, da);
      repeat (4) @(posedge prog_clk);
      #1;
      chk("err_held", crc_err, 1);
      chk("err_crc_held", crc_out, c);
      normal_load(0, 1'b0, -1, 1'b0);
      chk("err_cleared", crc_err, 0);

      // Abort on the 10th SHIFT cycle of a 64-bit load.
      start_load(64, 1'b0, -1, 1'b0, 32'h0, c);
      n = 0;
      while (chain_cnt < 9 && n < 500) begin
         @(posedge prog_clk);
         #1;
         start = 1'b0;
         n++;
      end
      chk("abort_reached", chain_cnt, 9);
      abort = 1'b1;
      #2;
      chk("abort_chain_en", chain_en, 0);
      chk("abort_s_ready", s_ready, 0);
      @(posedge prog_clk);
      #1;
      abort = 1'b0;
      chk("abort_idle", busy, 0);
      chk("abort_bits_left", exp_bits.size(), 55);
      flush_all();
      repeat (6) @(posedge prog_clk);
      chk("abort_no_done", chain_cnt, 9);

      normal_load(int'($urandom_range(33, 100)), 1'b0, -1, 1'b0);

      // Reset mid-SHIFT, asserted together with start and abort.
      start_load(64, 1'b0, -1, 1'b0, 32'h0, c);
      n = 0;
      while (chain_cnt < 5 && n < 500) begin
         @(posedge prog_clk);
         #1;
         start = 1'b0;
         n++;
      end
      prog_rst = 1'b1;
      start    = 1'b1;
      abort    = 1'b1;
      @(posedge prog_clk);
      #1;
      prog_rst = 1'b0;
      start    = 1'b0;
      abort    = 1'b0;
      chk_reset_values("midrst");
      flush_all();
      repeat (4) @(posedge prog_clk);
      #1;
      chk("midrst_stay_idle", busy, 0);

      // Stray starts while busy must not disturb the load in progress.
      normal_load(70, 1'b0, -1, 1'b1);

      for (int k = 0; k < 8; k++) begin
         normal_load(int'($urandom_range(1, 150)), 1'($urandom_range(0, 1)), -1,
                     1'($urandom_range(0, 1)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
